// File: rtl/boot_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | boot_pkg : shared state encoding and protocol bytes for the loader   |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
package boot_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_LO = 3'd1,
        S_LEN_HI = 3'd2,
        S_DATA   = 3'd3,
        S_CSUM   = 3'd4,
        S_RESP   = 3'd5,
        S_DONE   = 3'd6
    } boot_state_t;

    localparam logic [7:0] BOOT_MAGIC = 8'hA5;
    localparam logic [7:0] BOOT_ACK   = 8'h06;
    localparam logic [7:0] BOOT_NAK   = 8'h15;

    // States in which an inter-byte gap is being timed.
    function automatic logic boot_in_frame(input boot_state_t s);
        return (s == S_LEN_LO) || (s == S_LEN_HI) || (s == S_DATA) || (s == S_CSUM);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_boot_loader_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_boot_loader_if : UART rx/tx and imem write-port bundle          |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
interface uart_boot_loader_if #(
    parameter int ADDR_W = 9
) ();
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              tx_busy;
    logic [7:0]        tx_data;
    logic              tx_start;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic [3:0]        imem_wmask;

    // master = the loader; slave = the UART/memory environment.
    modport master (
        input  rx_data, rx_valid, tx_busy,
        output tx_data, tx_start, imem_we, imem_addr, imem_wdata, imem_wmask
    );

    modport slave (
        output rx_data, rx_valid, tx_busy,
        input  tx_data, tx_start, imem_we, imem_addr, imem_wdata, imem_wmask
    );
endinterface
`default_nettype wire

// File: rtl/boot_timeout.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | boot_timeout : inter-byte idle counter with clear/enable and expiry  |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
module boot_timeout #(
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int CNT_W          = 20
) (
    input  wire  clk,
    input  wire  rst,
    input  wire  i_clear,
    input  wire  i_enable,
    output logic o_expired
);
    localparam logic [CNT_W-1:0] LAST_IDLE = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (i_clear || !i_enable) begin
            count_d = '0;
        end else if (count_q != CNT_MAX) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Fires on the idle cycle that completes TIMEOUT_CYCLES idle cycles.
    assign o_expired = i_enable && !i_clear && (count_q == LAST_IDLE);

endmodule
`default_nettype wire

// File: rtl/uart_boot_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_boot_loader : receives a framed image over UART, writes imem,   |
// | verifies the checksum, answers ACK/NAK and releases the core.        |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
module uart_boot_loader
    import boot_pkg::*;
#(
    parameter int ADDR_W         = 9,
    parameter int MAX_WORDS      = 512,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int CNT_W          = 20
) (
    input  wire                clk,
    input  wire                rst,
    uart_boot_loader_if.master bus,
    output logic               core_hold,
    output logic               load_done,
    output logic               load_error
);
    localparam int              LEN_W   = ADDR_W + 1;
    localparam logic [15:0]     MAX_LEN = 16'(MAX_WORDS);

    boot_state_t       state_q,      state_d;
    logic [7:0]        len_lo_q,     len_lo_d;
    logic [LEN_W-1:0]  len_q,        len_d;
    logic [ADDR_W-1:0] word_idx_q,   word_idx_d;
    logic [1:0]        byte_cnt_q,   byte_cnt_d;
    logic [31:0]       word_q,       word_d;
    logic [7:0]        sum_q,        sum_d;
    logic [7:0]        resp_q,       resp_d;
    logic [7:0]        tx_data_q,    tx_data_d;
    logic              tx_start_q,   tx_start_d;
    logic              imem_we_q,    imem_we_d;
    logic [ADDR_W-1:0] imem_addr_q,  imem_addr_d;
    logic [31:0]       imem_wdata_q, imem_wdata_d;
    logic [3:0]        imem_wmask_q, imem_wmask_d;
    logic              core_hold_q,  core_hold_d;
    logic              load_done_q,  load_done_d;
    logic              load_error_q, load_error_d;

    logic              w_to_enable;
    logic              w_to_expired;
    logic [15:0]       w_len;
    logic [31:0]       w_word;
    logic [LEN_W-1:0]  w_last_idx;

    assign w_to_enable = boot_in_frame(state_q);

    boot_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_timeout (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (bus.rx_valid),
        .i_enable  (w_to_enable),
        .o_expired (w_to_expired)
    );

    always_comb begin
        state_d      = state_q;
        len_lo_d     = len_lo_q;
        len_d        = len_q;
        word_idx_d   = word_idx_q;
        byte_cnt_d   = byte_cnt_q;
        word_d       = word_q;
        sum_d        = sum_q;
        resp_d       = resp_q;
        tx_data_d    = tx_data_q;
        tx_start_d   = 1'b0;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        imem_wmask_d = 4'h0;
        core_hold_d  = core_hold_q;
        load_done_d  = load_done_q;
        load_error_d = load_error_q;

        w_len      = {bus.rx_data, len_lo_q};
        w_word     = word_q;
        w_word[{byte_cnt_q, 3'b000} +: 8] = bus.rx_data;
        w_last_idx = len_q - LEN_W'(1);

        case (state_q)
            S_IDLE: begin
                if (bus.rx_valid && bus.rx_data == BOOT_MAGIC) begin
                    load_error_d = 1'b0;
                    word_idx_d   = '0;
                    byte_cnt_d   = '0;
                    sum_d        = '0;
                    state_d      = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (bus.rx_valid) begin
                    len_lo_d = bus.rx_data;
                    state_d  = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (bus.rx_valid) begin
                    len_d = w_len[LEN_W-1:0];
                    if (w_len > MAX_LEN) begin
                        resp_d  = BOOT_NAK;
                        state_d = S_RESP;
                    end else if (w_len == 16'd0) begin
                        state_d = S_CSUM;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (bus.rx_valid) begin
                    word_d     = w_word;
                    sum_d      = sum_q + bus.rx_data;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    // Fourth byte completes the word; the write lands next cycle.
                    if (byte_cnt_q == 2'd3) begin
                        imem_we_d    = 1'b1;
                        imem_addr_d  = word_idx_q;
                        imem_wdata_d = w_word;
                        word_idx_d   = word_idx_q + 1'b1;
                        if ({1'b0, word_idx_q} == w_last_idx) begin
                            state_d = S_CSUM;
                        end
                    end
                end
            end
            S_CSUM: begin
                if (bus.rx_valid) begin
                    resp_d  = (bus.rx_data == sum_q) ? BOOT_ACK : BOOT_NAK;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (!bus.tx_busy) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = resp_q;
                    if (resp_q == BOOT_ACK) begin
                        state_d = S_DONE;
                    end else begin
                        load_error_d = 1'b1;
                        state_d      = S_IDLE;
                    end
                end
            end
            S_DONE: begin
                core_hold_d = 1'b0;
                load_done_d = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Expiry only occurs on a cycle without rx_valid, so it never races a byte.
        if (w_to_expired) begin
            resp_d  = BOOT_NAK;
            state_d = S_RESP;
        end

        if (imem_we_d) begin
            imem_wmask_d = 4'hF;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            len_lo_q     <= '0;
            len_q        <= '0;
            word_idx_q   <= '0;
            byte_cnt_q   <= '0;
            word_q       <= '0;
            sum_q        <= '0;
            resp_q       <= '0;
            tx_data_q    <= '0;
            tx_start_q   <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            imem_wmask_q <= 4'h0;
            core_hold_q  <= 1'b1;
            load_done_q  <= 1'b0;
            load_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_lo_q     <= len_lo_d;
            len_q        <= len_d;
            word_idx_q   <= word_idx_d;
            byte_cnt_q   <= byte_cnt_d;
            word_q       <= word_d;
            sum_q        <= sum_d;
            resp_q       <= resp_d;
            tx_data_q    <= tx_data_d;
            tx_start_q   <= tx_start_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            imem_wmask_q <= imem_wmask_d;
            core_hold_q  <= core_hold_d;
            load_done_q  <= load_done_d;
            load_error_q <= load_error_d;
        end
    end

    assign bus.tx_data    = tx_data_q;
    assign bus.tx_start   = tx_start_q;
    assign bus.imem_we    = imem_we_q;
    assign bus.imem_addr  = imem_addr_q;
    assign bus.imem_wdata = imem_wdata_q;
    assign bus.imem_wmask = imem_wmask_q;
    assign core_hold      = core_hold_q;
    assign load_done      = load_done_q;
    assign load_error     = load_error_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_boot_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_uart_boot_loader : scoreboard bench with a frame-level model      |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_uart_boot_loader;
    import boot_pkg::*;

    localparam int ADDR_W    = 9;
    localparam int MAX_WORDS = 512;
    localparam int TO_CYC    = 100;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic core_hold, load_done, load_error;

    uart_boot_loader_if #(.ADDR_W(ADDR_W)) bus ();

    uart_boot_loader #(
        .ADDR_W         (ADDR_W),
        .MAX_WORDS      (MAX_WORDS),
        .TIMEOUT_CYCLES (TO_CYC),
        .CNT_W          (20)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus.master),
        .core_hold  (core_hold),
        .load_done  (load_done),
        .load_error (load_error)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [ADDR_W-1:0] exp_addr_q[$];
    logic [31:0]       exp_data_q[$];
    logic [7:0]        exp_tx_q[$];
    logic [7:0]        frame[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Frame-level reference: parse the byte list directly and predict writes and reply.
    function automatic bit model_frame(input logic [7:0] f[$]);
        int         i = 0;
        int         len;
        int         p;
        logic [7:0] sum = 8'h00;
        while (i < f.size() && f[i] != BOOT_MAGIC) i++;
        len = int'(f[i+1]) + (int'(f[i+2]) << 8);
        if (len > MAX_WORDS) begin
            exp_tx_q.push_back(BOOT_NAK);
            return 1'b0;
        end
        p = i + 3;
        for (int w = 0; w < len; w++) begin
            exp_addr_q.push_back(ADDR_W'(w));
            exp_data_q.push_back({f[p+3], f[p+2], f[p+1], f[p]});
            sum = sum + f[p] + f[p+1] + f[p+2] + f[p+3];
            p += 4;
        end
        if (f[p] == sum) begin
            exp_tx_q.push_back(BOOT_ACK);
            return 1'b1;
        end
        exp_tx_q.push_back(BOOT_NAK);
        return 1'b0;
    endfunction

    // Monitor: pops expectations whenever the DUT presents a write or a reply.
    logic prev_rx_valid = 1'b0;
    logic prev_tx_start = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            if (bus.imem_we) begin
                if (exp_addr_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_write: got addr %h data %h want no write",
                             bus.imem_addr, bus.imem_wdata);
                end else begin
                    check("write_addr", 32'(bus.imem_addr), 32'(exp_addr_q.pop_front()));
                    check("write_data", bus.imem_wdata, exp_data_q.pop_front());
                    check("write_mask", 32'(bus.imem_wmask), 32'hF);
                    check("write_follows_byte", 32'(prev_rx_valid), 32'd1);
                end
            end
            if (bus.tx_start) begin
                check("tx_pulse_width", 32'(prev_tx_start), 32'd0);
                if (exp_tx_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_tx: got %h want no transmit", bus.tx_data);
                end else begin
                    check("tx_byte", 32'(bus.tx_data), 32'(exp_tx_q.pop_front()));
                end
            end
        end
        prev_rx_valid <= bus.rx_valid;
        prev_tx_start <= bus.tx_start;
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_core_hold"},  32'(core_hold),      32'd1);
        check({tag, "_load_done"},  32'(load_done),      32'd0);
        check({tag, "_load_error"}, 32'(load_error),     32'd0);
        check({tag, "_imem_we"},    32'(bus.imem_we),    32'd0);
        check({tag, "_tx_start"},   32'(bus.tx_start),   32'd0);
        check({tag, "_tx_data"},    32'(bus.tx_data),    32'd0);
        check({tag, "_imem_addr"},  32'(bus.imem_addr),  32'd0);
        check({tag, "_imem_wdata"}, bus.imem_wdata,      32'd0);
        check({tag, "_imem_wmask"}, 32'(bus.imem_wmask), 32'd0);
    endtask

    task automatic do_reset(input string tag, input bit check_outs);
        rst = 1'b0;
        bus.rx_valid = 1'b0;
        bus.tx_busy  = 1'b0;
        @(posedge clk); #1;
        if (check_outs) check_reset_outputs(tag);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        @(posedge clk); #1;
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(posedge clk); #1;
        bus.rx_valid = 1'b0;
        repeat (gap) @(posedge clk);
    endtask

    task automatic send_frame(input logic [7:0] f[$], input int maxgap);
        foreach (f[i]) send_byte(f[i], int'($urandom_range(maxgap, 0)));
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while ((exp_tx_q.size() != 0 || exp_addr_q.size() != 0) && n < 3000) begin
            @(posedge clk);
            n++;
        end
        if (n >= 3000) begin
            total++; bad++;
            $display("FAIL %s_wait: got %0d replies %0d writes outstanding want 0",
                     tag, exp_tx_q.size(), exp_addr_q.size());
            exp_tx_q.delete(); exp_addr_q.delete(); exp_data_q.delete();
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_flags(input string tag, input bit ack);
        check({tag, "_core_hold"},  32'(core_hold),  32'(!ack));
        check({tag, "_load_done"},  32'(load_done),  32'(ack));
        check({tag, "_load_error"}, 32'(load_error), 32'(!ack));
    endtask

    initial begin
        bit         ack;
        int         n;
        int         len;
        logic [7:0] g;
        logic [7:0] sum;
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        bus.tx_busy  = 1'b0;

        do_reset("reset", 1'b1);

        // Two-word image with a correct checksum, then traffic after DONE is ignored.
        frame = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                  8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h4C};
        ack = model_frame(frame);
        send_frame(frame, 2);
        wait_done("t1");
        check_flags("t1", 1'b1);
        send_frame(frame, 1);
        repeat (5) @(posedge clk); #1;
        check("t1_done_sticky", 32'(core_hold), 32'd0);

        // Bad checksum NAKs, then the corrected frame ACKs.
        do_reset("t2_reset", 1'b0);
        frame[11] = 8'h6D;
        ack = model_frame(frame);
        send_frame(frame, 2);
        wait_done("t2_bad");
        check_flags("t2_bad", 1'b0);
        frame[11] = 8'h4C;
        ack = model_frame(frame);
        send_frame(frame, 2);
        wait_done("t2_good");
        check_flags("t2_good", 1'b1);

        // Oversized length: NAK straight after the header, no writes.
        do_reset("t3_reset", 1'b0);
        frame = '{8'hA5, 8'h01, 8'h02};
        ack = model_frame(frame);
        send_frame(frame, 1);
        wait_done("t3");
        check_flags("t3", 1'b0);

        // Leading garbage, empty image.
        do_reset("t4_reset", 1'b0);
        frame = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00, 8'h00};
        ack = model_frame(frame);
        send_frame(frame, 1);
        wait_done("t4");
        check_flags("t4", 1'b1);

        // Stall mid-payload: NAK about TO_CYC cycles after the last byte.
        do_reset("t5_reset", 1'b0);
        exp_tx_q.push_back(BOOT_NAK);
        frame = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22};
        send_frame(frame, 0);
        n = 0;
        while (!bus.tx_start && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        total++;
        if (n < TO_CYC || n > TO_CYC + 2) begin
            bad++;
            $display("FAIL t5_timeout_latency: got %0d cycles want %0d..%0d", n, TO_CYC, TO_CYC + 2);
        end
        wait_done("t5");
        check_flags("t5", 1'b0);
        frame = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA};
        ack = model_frame(frame);
        send_frame(frame, 1);
        wait_done("t5_restart");
        check_flags("t5_restart", 1'b1);

        // Transmitter busy holds off the reply.
        do_reset("t6_reset", 1'b0);
        frame = '{8'hA5, 8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h0E};
        ack = model_frame(frame);
        for (int i = 0; i < 7; i++) send_byte(frame[i], 1);
        bus.tx_busy = 1'b1;
        send_byte(frame[7], 0);
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            check("t6_tx_start_held", 32'(bus.tx_start), 32'd0);
        end
        bus.tx_busy = 1'b0;
        wait_done("t6");
        check_flags("t6", 1'b1);

        // Reset after five payload bytes: the first word is already written.
        do_reset("t7_pre", 1'b0);
        exp_addr_q.push_back('0);
        exp_data_q.push_back(32'h4433_2211);
        frame = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        send_frame(frame, 1);
        @(posedge clk); #1;
        check("t7_first_word_written", 32'(exp_addr_q.size()), 32'd0);
        do_reset("t7_mid_reset", 1'b1);

        // Randomised frames, some with corrupted checksums.
        for (int r = 0; r < 6; r++) begin
            do_reset("rnd_reset", 1'b0);
            frame.delete();
            for (int k = 0; k < int'($urandom_range(2, 0)); k++) begin
                g = 8'($urandom_range(255, 0));
                if (g == BOOT_MAGIC) g = 8'h00;
                frame.push_back(g);
            end
            len = int'($urandom_range(6, 0));
            frame.push_back(BOOT_MAGIC);
            frame.push_back(8'(len));
            frame.push_back(8'h00);
            sum = 8'h00;
            for (int k = 0; k < 4 * len; k++) begin
                g = 8'($urandom_range(255, 0));
                frame.push_back(g);
                sum = sum + g;
            end
            if ($urandom_range(3, 0) == 0) sum = sum + 8'($urandom_range(255, 1));
            frame.push_back(sum);
            ack = model_frame(frame);
            send_frame(frame, 4);
            wait_done("rnd");
            check_flags("rnd", ack);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running want finished");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
